// File: rtl/mult32x32_ctrl.sv
// rtl/mult32x32_ctrl.sv - sequencing controller for the 32x32 multiplier
//
// Latches two 32-bit operands on an accepted start and steps the external
// arithmetic unit through up to four 16x16 partial products (S00..S11).
// When the sequence ends it registers the unit's 64-bit product into result
// and pulses done for one cycle.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start, a_in, b_in request and operands, sampled only in IDLE
//   product           product register read back from the arithmetic unit
//   a, b              latched operands driven to the arithmetic unit
//   a_sel, b_sel      half selects (1 = low half, 0 = high half)
//   shift_sel         00 <<0, 01 <<16, 10 <<32, 11 add zero
//   upd_prod          accumulate the shifted partial product this edge
//   clr_prod          clear the product this edge
//   busy, done        status; done is a one-cycle pulse with result valid
//   result            final product, held until the next completion
module mult32x32_ctrl #(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [63:0] product,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        a_sel,
  output logic        b_sel,
  output logic [1:0]  shift_sel,
  output logic        upd_prod,
  output logic        clr_prod,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S00  = 3'd1,
    S01  = 3'd2,
    S10  = 3'd3,
    S11  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   a_hi, b_hi;

  // With early termination off every step is treated as having a nonzero
  // upper half, so the full four-step sequence always runs.
  assign a_hi = EARLY_TERM ? (a[31:16] != 16'd0) : 1'b1;
  assign b_hi = EARLY_TERM ? (b[31:16] != 16'd0) : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a      <= 32'd0;
      b      <= 32'd0;
      result <= 64'd0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a <= a_in;
        b <= b_in;
      end
      // The product register already holds the last step's sum in DONE.
      if (state == DONE) begin
        result <= product;
        done   <= 1'b1;
      end else begin
        done   <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = 2'b11;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // Product clear coincides with operand capture.
        clr_prod = start;
        if (start) state_nxt = S00;
      end
      S00: begin
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'b00;
        upd_prod  = 1'b1;
        if (b_hi)      state_nxt = S01;
        else if (a_hi) state_nxt = S10;
        else           state_nxt = DONE;
      end
      S01: begin
        a_sel     = 1'b1;
        b_sel     = 1'b0;
        shift_sel = 2'b01;
        upd_prod  = 1'b1;
        state_nxt = a_hi ? S10 : DONE;
      end
      S10: begin
        a_sel     = 1'b0;
        b_sel     = 1'b1;
        shift_sel = 2'b01;
        upd_prod  = 1'b1;
        state_nxt = b_hi ? S11 : DONE;
      end
      S11: begin
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = 2'b10;
        upd_prod  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// tb/tb_mult32x32_ctrl.sv - bench for mult32x32_ctrl with EARLY_TERM=1 and EARLY_TERM=0
module tb_mult32x32_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;

  logic [63:0] product_w [2];
  logic [31:0] a_w       [2];
  logic [31:0] b_w       [2];
  logic        a_sel_w   [2];
  logic        b_sel_w   [2];
  logic [1:0]  shift_w   [2];
  logic        upd_w     [2];
  logic        clr_w     [2];
  logic        busy_w    [2];
  logic        done_w    [2];
  logic [63:0] result_w  [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance 0 terminates early, instance 1 always runs four steps. Each
  // has its own arithmetic unit model accumulating the selected partial
  // products.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] ah, bh;
    logic [31:0] m;
    logic [63:0] pp;

    mult32x32_ctrl #(.EARLY_TERM(g == 0 ? 1'b1 : 1'b0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .product(product_w[g]), .a(a_w[g]), .b(b_w[g]),
      .a_sel(a_sel_w[g]), .b_sel(b_sel_w[g]), .shift_sel(shift_w[g]),
      .upd_prod(upd_w[g]), .clr_prod(clr_w[g]), .busy(busy_w[g]),
      .done(done_w[g]), .result(result_w[g])
    );

    assign ah = a_sel_w[g] ? a_w[g][15:0] : a_w[g][31:16];
    assign bh = b_sel_w[g] ? b_w[g][15:0] : b_w[g][31:16];
    assign m  = ah * bh;

    always_comb begin
      pp = 64'd0;
      case (shift_w[g])
        2'b00:   pp = {32'd0, m};
        2'b01:   pp = {32'd0, m} << 16;
        2'b10:   pp = {32'd0, m} << 32;
        default: pp = 64'd0;
      endcase
    end

    always @(posedge clk or posedge reset) begin
      if (reset)           product_w[g] <= 64'd0;
      else if (clr_w[g])   product_w[g] <= 64'd0;
      else if (upd_w[g])   product_w[g] <= product_w[g] + pp;
    end
  end

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic [63:0] er;
    int          ec;
    bit          poke;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  // Steps visited with early termination: S00 always, S01 if b upper half
  // nonzero, S10 if a upper half nonzero, S11 if both.
  function automatic int steps_of(input logic [31:0] av, input logic [31:0] bv);
    bit ahi, bhi;
    ahi = (av[31:16] != 0);
    bhi = (bv[31:16] != 0);
    return 1 + int'(bhi) + int'(ahi) + int'(ahi && bhi);
  endfunction

  // Expected {a_sel,b_sel,shift_sel} per update cycle for the early-term unit.
  function automatic logic [15:0] seq_of(input logic [31:0] av, input logic [31:0] bv);
    logic [15:0] s;
    bit ahi, bhi;
    ahi = (av[31:16] != 0);
    bhi = (bv[31:16] != 0);
    s = 16'h000C;
    if (bhi)        s = {s[11:0], 4'h9};
    if (ahi)        s = {s[11:0], 4'h5};
    if (ahi && bhi) s = {s[11:0], 4'h2};
    return s;
  endfunction

  // Called just after a falling edge; starts a multiply at the next rising
  // edge and follows both instances until each has pulsed done.
  task automatic do_mul(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] er, input int ec0, input bit poke);
    int          dcyc [2];
    int          ndone [2];
    int          upds [2];
    bit          busy_ok [2];
    logic [63:0] res [2];
    logic [15:0] seq0;
    a_in = av;
    b_in = bv;
    start = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("clr_at_start", i, clr_w[i], 1);
      dcyc[i] = 0; ndone[i] = 0; upds[i] = 0; busy_ok[i] = 1; res[i] = 0;
    end
    seq0 = 16'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done_w[i]) begin
          ndone[i]++;
          if (dcyc[i] == 0) begin
            dcyc[i] = c;
            res[i] = result_w[i];
          end
        end else if (dcyc[i] == 0 && !busy_w[i]) begin
          busy_ok[i] = 0;
        end
        if (upd_w[i]) upds[i]++;
      end
      if (upd_w[0]) seq0 = {seq0[11:0], a_sel_w[0], b_sel_w[0], shift_w[0]};
      if (c == 1) start = 1'b0;
      if (poke && c == 2) begin
        a_in = ~av;
        b_in = ~bv;
        start = 1'b1;
      end
      if (poke && c == 3) start = 1'b0;
      if (dcyc[0] != 0 && dcyc[1] != 0) break;
    end
    chk("done_cycle", 0, dcyc[0], ec0);
    chk("done_cycle", 1, dcyc[1], 6);
    chk("steps_seq", 0, seq0, seq_of(av, bv));
    chk("upd_count", 1, upds[1], 4);
    for (int i = 0; i < 2; i++) begin
      chk("result", i, res[i], er);
      chk("done_pulses", i, ndone[i], 1);
      chk("busy_during", i, busy_ok[i], 1);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    vecs[0] = '{32'h00020003, 32'h00040005, 64'h000000080016000F, 6, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 6, 1'b0};
    vecs[2] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 3, 1'b0};
    vecs[3] = '{32'h00020003, 32'h00040005, 64'h000000080016000F, 6, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("reset_busy", i, busy_w[i], 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("idle_busy", i, busy_w[i], 0);
      chk("idle_done", i, done_w[i], 0);
      chk("idle_result", i, result_w[i], 0);
      chk("idle_upd", i, upd_w[i], 0);
      chk("idle_clr", i, clr_w[i], 0);
      chk("idle_shift", i, shift_w[i], 2'b11);
    end

    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      do_mul(vecs[v].av, vecs[v].bv, vecs[v].er, vecs[v].ec, vecs[v].poke);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    @(negedge clk);
    do_mul(32'hFFFFFFFF, 32'h00010001, 64'hFFFFFFFF * 64'h00010001, 6, 1'b0);
    do_mul(32'h12345678, 32'h9ABCDEF0, 64'h12345678 * 64'h9ABCDEF0, 6, 1'b0);

    // Reset in S10 of a full-length multiply.
    @(negedge clk);
    a_in = 32'h00030007;
    b_in = 32'h00050009;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("pre_reset_busy", i, busy_w[i], 1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_reset_busy", i, busy_w[i], 0);
      chk("mid_reset_result", i, result_w[i], 0);
      chk("mid_reset_done", i, done_w[i], 0);
      chk("mid_reset_upd", i, upd_w[i], 0);
      chk("mid_reset_a", i, a_w[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("no_done_after_reset", i, done_w[i], 0);
    end
    do_mul(32'h00010000, 32'h00010000, 64'h0000000100000000, 6, 1'b0);

    // Random operands, upper/lower halves zeroed at random.
    for (int r = 0; r < 24; r++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra[31:16] = 16'd0;
        1: rb[31:16] = 16'd0;
        2: begin ra[31:16] = 16'd0; rb[31:16] = 16'd0; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'd0;
      @(negedge clk);
      do_mul(ra, rb, {32'd0, ra} * {32'd0, rb}, steps_of(ra, rb) + 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
